fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter A, default 10, instruction address width (matches 1024-entry instruction ROM).
REQ-002 Parameter OFS_W, default 8, per-program offset width; A = 2 + OFS_W SHALL hold.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin execution of the selected program.
REQ-006 program_num  input  2  program select, sampled only when start is accepted.
REQ-007 stall  input  1  hold current address this cycle.
REQ-008 branch_taken  input  1  load branch_target as next offset.
REQ-009 branch_target  input  OFS_W  target offset within current program region.
REQ-010 halt  input  1  decoded halt instruction at current address.
REQ-011 instr_address  output  A  ROM address = {prog_sel, pc_ofs}.
REQ-012 running  output  1  high in RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 overflow  output  1  set when program ran past last offset.
REQ-015 instr_count  output  16  instructions retired in current run, saturating.

Function
REQ-016 FSM states IDLE, RUN, DONE; all outputs registered or decoded from registers only.
REQ-017 IDLE or DONE with start=1: latch program_num into prog_sel, pc_ofs<=0, instr_count<=0, overflow<=0, go RUN next cycle.
REQ-018 start in RUN SHALL be ignored.
REQ-019 RUN per-cycle priority: halt > stall > branch_taken > sequential increment.
REQ-020 halt=1 in RUN: go DONE, pc_ofs held, instr_count incremented (halt counts as retired).
REQ-021 stall=1 (no halt): pc_ofs and instr_count held.
REQ-022 branch_taken=1: pc_ofs<=branch_target next cycle, instr_count+1.
REQ-023 otherwise pc_ofs<=pc_ofs+1, instr_count+1.
REQ-024 Sequential increment at pc_ofs=2**OFS_W-1: go DONE, overflow<=1, pc_ofs held; no wrap into next program region.
REQ-025 Branch at last offset is legal and SHALL NOT set overflow.
REQ-026 instr_count saturates at 16'hFFFF.
REQ-027 instr_address valid from the cycle RUN is entered; ROM read is combinational so instruction is same-cycle, zero added latency.
REQ-028 In IDLE/DONE instr_address holds last value; stall/branch/halt ignored.
REQ-029 done stays high until start accepted; overflow, instr_count, prog_sel stay valid in DONE.

Reset
REQ-030 rst_n low (any time, including mid-RUN) SHALL immediately force IDLE, pc_ofs=0, prog_sel=0, instr_count=0, overflow=0, running=0, done=0, instr_address=0.
REQ-031 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package fetch_pkg holds state enum (IDLE, RUN, DONE), A, OFS_W, COUNT_W=16.
REQ-033 One sub-module sat_counter (width param, clear, enable, saturate) implements instr_count.
REQ-034 No memory inside fetch_ctrl; it drives the instruction ROM address port only.

Verification
REQ-035 Reset, start with program_num=2, no branches, halt at 4th cycle -> addresses 0x200,0x201,0x202,0x203; done=1; instr_count=4.
REQ-036 program_num=1, branch_taken at offset 3 with target 0x10 -> address sequence 0x100..0x103, 0x110; no overflow.
REQ-037 stall held 3 cycles at offset 5 with branch_taken also high -> address 5 held 3 cycles, count unchanged, branch ignored.
REQ-038 program_num=0, no halt for 256 cycles -> at 0x0FF goes DONE, overflow=1, address stays 0x0FF, count=256.
REQ-039 rst_n pulsed low mid-RUN at offset 7 -> outputs zero asynchronously, IDLE; start in RUN ignored; start in DONE restarts with count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch controller.
// The ROM is 1024 entries: 4 program regions of 256 offsets each.
package fetch_pkg;

  localparam int OFS_W   = 8;
  localparam int A       = 2 + OFS_W;
  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Control and status bundle between the sequencer (master) and fetch_ctrl (slave).
// The slave drives the instruction ROM address and the status outputs.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int A     = fetch_pkg::A,
  parameter int OFS_W = fetch_pkg::OFS_W
);

  logic               start;
  logic [1:0]         program_num;
  logic               stall;
  logic               branch_taken;
  logic [OFS_W-1:0]   branch_target;
  logic               halt;
  logic [A-1:0]       instr_address;
  logic               running;
  logic               done;
  logic               overflow;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output start, program_num, stall, branch_taken, branch_target, halt,
    input  instr_address, running, done, overflow, instr_count
  );

  modport slave (
    input  start, program_num, stall, branch_taken, branch_target, halt,
    output instr_address, running, done, overflow, instr_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// clear takes priority over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a program region of the ROM, honouring
// halt > stall > branch > sequential priority, and counts retired instructions.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int A     = fetch_pkg::A,
  parameter int OFS_W = fetch_pkg::OFS_W
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.slave  bus
);

  if (A != 2 + OFS_W) begin : g_width_check
    $error("fetch_ctrl: A must equal 2 + OFS_W");
  end

  localparam logic [OFS_W-1:0] LAST_OFS = {OFS_W{1'b1}};

  fetch_state_e     state, state_nx;
  logic [1:0]       prog_sel, prog_sel_nx;
  logic [OFS_W-1:0] pc_ofs, pc_ofs_nx;
  logic             overflow_q, overflow_nx;
  logic             cnt_clear, cnt_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Running off the end of a region stops the program instead of wrapping into the next one.
  always_comb begin
    state_nx    = state;
    prog_sel_nx = prog_sel;
    pc_ofs_nx   = pc_ofs;
    overflow_nx = overflow_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nx    = RUN;
          prog_sel_nx = bus.program_num;
          pc_ofs_nx   = '0;
          overflow_nx = 1'b0;
          cnt_clear   = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt) begin
          state_nx = DONE;
          cnt_en   = 1'b1;
        end else if (!bus.stall) begin
          cnt_en = 1'b1;
          if (bus.branch_taken) begin
            pc_ofs_nx = bus.branch_target;
          end else if (pc_ofs == LAST_OFS) begin
            state_nx    = DONE;
            overflow_nx = 1'b1;
          end else begin
            pc_ofs_nx = pc_ofs + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_sel   <= '0;
      pc_ofs     <= '0;
      overflow_q <= 1'b0;
    end else begin
      prog_sel   <= prog_sel_nx;
      pc_ofs     <= pc_ofs_nx;
      overflow_q <= overflow_nx;
    end
  end

  sat_counter #(
    .W (COUNT_W)
  ) u_instr_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (bus.instr_count)
  );

  assign bus.instr_address = {prog_sel, pc_ofs};
  assign bus.running       = (state == RUN);
  assign bus.done          = (state == DONE);
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed program scenarios plus random traffic
// compared against a per-cycle behavioural model of the fetch rules.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fetch_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a program is "active" at some region and offset.
  bit m_active, m_done, m_ovf;
  int m_prog, m_ofs, m_count;

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_ovf = 0;
    m_prog = 0; m_ofs = 0; m_count = 0;
  endfunction

  function automatic void model_step(bit st, int pn, bit stl, bit br, int tgt, bit hlt);
    if (!m_active) begin
      if (st) begin
        m_active = 1; m_done = 0; m_ovf = 0;
        m_prog = pn; m_ofs = 0; m_count = 0;
      end
    end else if (hlt) begin
      m_active = 0; m_done = 1;
      m_count = (m_count < 65535) ? m_count + 1 : 65535;
    end else if (!stl) begin
      m_count = (m_count < 65535) ? m_count + 1 : 65535;
      if (br) m_ofs = tgt;
      else if (m_ofs == 255) begin
        m_active = 0; m_done = 1; m_ovf = 1;
      end else m_ofs = m_ofs + 1;
    end
  endfunction

  task automatic clear_inputs();
    bus.start = 0; bus.program_num = 0; bus.stall = 0;
    bus.branch_taken = 0; bus.branch_target = 0; bus.halt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [1:0] pn);
    bus.start = 1; bus.program_num = pn;
    tick();
    bus.start = 0; bus.program_num = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++; if (bus.instr_address !== 10'h000) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=000", bus.instr_address); end
    total++; if (bus.running !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b%b exp=00", bus.running, bus.done); end
    total++; if (bus.overflow !== 1'b0 || bus.instr_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_ovf_cnt got=%b/%h exp=0/0000", bus.overflow, bus.instr_count); end
    rst_n = 1;
  endtask

  task automatic test_halt_run();
    logic [9:0] exp_addr;
    launch(2'd2);
    for (int i = 0; i < 4; i++) begin
      exp_addr = 10'h200 + 10'(i);
      total++; if (bus.instr_address !== exp_addr || bus.running !== 1'b1) begin bad++; $display("[TB] FAIL halt_addr%0d got=%h run=%b exp=%h run=1", i, bus.instr_address, bus.running, exp_addr); end
      if (i == 3) bus.halt = 1;
      tick();
    end
    bus.halt = 0;
    total++; if (bus.done !== 1'b1 || bus.running !== 1'b0) begin bad++; $display("[TB] FAIL halt_done got=%b exp=1", bus.done); end
    total++; if (bus.instr_count !== 16'd4) begin bad++; $display("[TB] FAIL halt_count got=%0d exp=4", bus.instr_count); end
    total++; if (bus.instr_address !== 10'h203) begin bad++; $display("[TB] FAIL halt_hold got=%h exp=203", bus.instr_address); end
  endtask

  task automatic test_branch();
    logic [9:0] exp_addr;
    launch(2'd1);
    for (int i = 0; i < 4; i++) begin
      exp_addr = 10'h100 + 10'(i);
      total++; if (bus.instr_address !== exp_addr) begin bad++; $display("[TB] FAIL branch_seq%0d got=%h exp=%h", i, bus.instr_address, exp_addr); end
      if (i == 3) begin bus.branch_taken = 1; bus.branch_target = 8'h10; end
      tick();
    end
    bus.branch_taken = 0;
    total++; if (bus.instr_address !== 10'h110) begin bad++; $display("[TB] FAIL branch_target got=%h exp=110", bus.instr_address); end
    total++; if (bus.overflow !== 1'b0 || bus.instr_count !== 16'd4) begin bad++; $display("[TB] FAIL branch_ovf_cnt got=%b/%0d exp=0/4", bus.overflow, bus.instr_count); end
    bus.halt = 1; tick(); bus.halt = 0;
  endtask

  task automatic test_stall();
    launch(2'd3);
    repeat (5) tick();
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 8'h40;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (bus.instr_address !== 10'h305 || bus.instr_count !== 16'd5) begin bad++; $display("[TB] FAIL stall_hold%0d got=%h/%0d exp=305/5", k, bus.instr_address, bus.instr_count); end
    end
    bus.stall = 0; bus.branch_taken = 0;
    tick();
    total++; if (bus.instr_address !== 10'h306 || bus.instr_count !== 16'd6) begin bad++; $display("[TB] FAIL stall_release got=%h/%0d exp=306/6", bus.instr_address, bus.instr_count); end
    bus.halt = 1; tick(); bus.halt = 0;
  endtask

  task automatic test_overflow();
    launch(2'd0);
    repeat (255) tick();
    total++; if (bus.instr_address !== 10'h0FF || bus.running !== 1'b1) begin bad++; $display("[TB] FAIL ovf_last got=%h run=%b exp=0ff run=1", bus.instr_address, bus.running); end
    tick();
    total++; if (bus.done !== 1'b1 || bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flags got=%b/%b exp=1/1", bus.done, bus.overflow); end
    total++; if (bus.instr_address !== 10'h0FF || bus.instr_count !== 16'd256) begin bad++; $display("[TB] FAIL ovf_addr_cnt got=%h/%0d exp=0ff/256", bus.instr_address, bus.instr_count); end
    bus.branch_taken = 1; bus.branch_target = 8'h33; bus.halt = 1;
    tick();
    clear_inputs();
    total++; if (bus.instr_address !== 10'h0FF || bus.done !== 1'b1 || bus.instr_count !== 16'd256) begin bad++; $display("[TB] FAIL done_ignore got=%h/%b/%0d exp=0ff/1/256", bus.instr_address, bus.done, bus.instr_count); end
  endtask

  task automatic test_branch_last();
    launch(2'd1);
    repeat (255) tick();
    bus.branch_taken = 1; bus.branch_target = 8'h20;
    tick();
    bus.branch_taken = 0;
    total++; if (bus.instr_address !== 10'h120 || bus.overflow !== 1'b0 || bus.running !== 1'b1) begin bad++; $display("[TB] FAIL branch_last got=%h/%b/%b exp=120/0/1", bus.instr_address, bus.overflow, bus.running); end
    bus.halt = 1; tick(); bus.halt = 0;
  endtask

  task automatic test_reset_mid_run();
    launch(2'd2);
    repeat (7) tick();
    total++; if (bus.instr_address !== 10'h207) begin bad++; $display("[TB] FAIL mid_pre got=%h exp=207", bus.instr_address); end
    #2 rst_n = 0;
    #1;
    total++; if (bus.instr_address !== 10'h000 || bus.running !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("[TB] FAIL mid_async got=%h/%b/%b exp=000/0/0", bus.instr_address, bus.running, bus.done); end
    total++; if (bus.instr_count !== 16'h0 || bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL mid_async_cnt got=%0d/%b exp=0/0", bus.instr_count, bus.overflow); end
    @(negedge clk);
    rst_n = 1;
    launch(2'd2);
    total++; if (bus.instr_address !== 10'h200 || bus.running !== 1'b1) begin bad++; $display("[TB] FAIL first_start got=%h/%b exp=200/1", bus.instr_address, bus.running); end
    launch(2'd1);
    total++; if (bus.instr_address !== 10'h201 || bus.instr_count !== 16'd1) begin bad++; $display("[TB] FAIL start_in_run got=%h/%0d exp=201/1", bus.instr_address, bus.instr_count); end
    bus.halt = 1; tick(); bus.halt = 0;
    total++; if (bus.done !== 1'b1 || bus.instr_count !== 16'd2) begin bad++; $display("[TB] FAIL mid_halt got=%b/%0d exp=1/2", bus.done, bus.instr_count); end
    launch(2'd3);
    total++; if (bus.instr_address !== 10'h300 || bus.instr_count !== 16'd0 || bus.done !== 1'b0) begin bad++; $display("[TB] FAIL restart got=%h/%0d/%b exp=300/0/0", bus.instr_address, bus.instr_count, bus.done); end
    bus.halt = 1; tick(); bus.halt = 0;
  endtask

  task automatic test_random();
    logic [9:0] exp_addr;
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.start         = ($urandom_range(0, 7) == 0);
      bus.program_num   = 2'($urandom_range(0, 3));
      bus.halt          = ($urandom_range(0, 59) == 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.branch_taken  = ($urandom_range(0, 9) == 0);
      bus.branch_target = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(224, 255));
      @(posedge clk);
      model_step(bus.start, int'(bus.program_num), bus.stall, bus.branch_taken, int'(bus.branch_target), bus.halt);
      @(negedge clk);
      exp_addr = 10'(m_prog * 256 + m_ofs);
      total++;
      if (bus.instr_address !== exp_addr || bus.running !== m_active || bus.done !== m_done ||
          bus.overflow !== m_ovf || bus.instr_count !== 16'(m_count)) begin
        bad++;
        $display("[TB] FAIL rand%0d got=%h/%b/%b/%b/%0d exp=%h/%b/%b/%b/%0d", n,
                 bus.instr_address, bus.running, bus.done, bus.overflow, bus.instr_count,
                 exp_addr, m_active, m_done, m_ovf, m_count);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_halt_run();
    test_branch();
    test_stall();
    test_overflow();
    test_branch_last();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
